// File: rtl/legv8_pkg.sv
// Shared constants for the LEGv8 execute stage: ALU-control codes,
// ALUOp encodings from Control, and the R-type opcodes the ALU decoder recognises.
package legv8_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

endpackage

// File: rtl/alu_core.sv
// Combinational LEGv8 ALU producing the result plus N/Z/C/V flags.
module alu_core
    import legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       aluCtl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    logic             isSub;
    logic [WIDTH-1:0] bOperand;
    logic [WIDTH:0]   sumExt;

    // Subtraction reuses the adder as a + ~b + 1, so carry out means "no borrow".
    assign isSub    = (aluCtl == ALU_SUB);
    assign bOperand = isSub ? ~b : b;
    assign sumExt   = {1'b0, a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (aluCtl)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD,
            ALU_SUB: begin
                result = sumExt[WIDTH-1:0];
                carry  = sumExt[WIDTH];
                ovf    = (a[WIDTH-1] == bOperand[WIDTH-1]) && (sumExt[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_PASSB: result = b;
            ALU_NOR:   result = ~(a | b);
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule

// File: rtl/alu_ctl_decode.sv
// Combinational ALU-control decode from Control's ALUOp and the instruction opcode.
module alu_ctl_decode
    import legv8_pkg::*;
(
    input  logic [1:0]  aluOp,
    input  logic [10:0] opcode,
    output logic [3:0]  aluCtl
);

    // ALUOp1 selects R-type decode; otherwise ALUOp0 picks CBZ pass-through over load/store add.
    // Unrecognised R-type opcodes fall back to ADD.
    always_comb begin
        aluCtl = ALU_ADD;
        if (aluOp[1]) begin
            case (opcode)
                OP_ADD:  aluCtl = ALU_ADD;
                OP_SUB:  aluCtl = ALU_SUB;
                OP_AND:  aluCtl = ALU_AND;
                OP_ORR:  aluCtl = ALU_OR;
                default: aluCtl = ALU_ADD;
            endcase
        end else if (aluOp[0]) begin
            aluCtl = ALU_PASSB;
        end
    end

endmodule

// File: rtl/generic_adder.sv
// Plain WIDTH-bit adder wrapping modulo 2^WIDTH; shared by the PC+4 and branch-target paths.
module generic_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/alu_execute_stage.sv
// LEGv8 execute stage: decode, ALU and PC adders feeding the EX/MEM output register bank.
module alu_execute_stage
    import legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    logic [3:0]       aluCtlNext;
    logic [WIDTH-1:0] resultNext;
    logic             zeroNext;
    logic             negNext;
    logic             carryNext;
    logic             ovfNext;
    logic [WIDTH-1:0] pcPlus4Next;
    logic [WIDTH-1:0] branchTargetNext;
    logic [WIDTH-1:0] branchOffset;

    alu_ctl_decode ctlDecode (
        .aluOp  (alu_op),
        .opcode (opcode),
        .aluCtl (aluCtlNext)
    );

    alu_core #(.WIDTH(WIDTH)) aluCore (
        .aluCtl (aluCtlNext),
        .a      (a),
        .b      (b),
        .result (resultNext),
        .zero   (zeroNext),
        .neg    (negNext),
        .carry  (carryNext),
        .ovf    (ovfNext)
    );

    // Word offset to byte offset; the top two immediate bits shift out.
    assign branchOffset = {imm[WIDTH-3:0], 2'b00};

    generic_adder #(.WIDTH(WIDTH)) pcIncAdder (
        .x   (pc),
        .y   (WIDTH'(4)),
        .sum (pcPlus4Next)
    );

    generic_adder #(.WIDTH(WIDTH)) branchAdder (
        .x   (pc),
        .y   (branchOffset),
        .sum (branchTargetNext)
    );

    // EX/MEM register bank: reset wins over enable, and a low enable holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctl       <= '0;
            result        <= '0;
            zero          <= 1'b0;
            neg           <= 1'b0;
            carry         <= 1'b0;
            ovf           <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
        end else if (en) begin
            alu_ctl       <= aluCtlNext;
            result        <= resultNext;
            zero          <= zeroNext;
            neg           <= negNext;
            carry         <= carryNext;
            ovf           <= ovfNext;
            pc_plus4      <= pcPlus4Next;
            branch_target <= branchTargetNext;
        end
    end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed cases then randomized traffic
// compared against an arithmetic reference model of the registered outputs.
module tb_alu_execute_stage;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic [63:0] p4;
        logic [63:0] bt;
    } outs_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [63:0] a, b, imm, pc;
    logic [3:0]  alu_ctl;
    logic [63:0] result;
    logic        zero, neg, carry, ovf;
    logic [63:0] pc_plus4, branch_target;

    int    errorCount = 0;
    int    checkCount = 0;
    outs_t expected;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    alu_execute_stage #(.WIDTH(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .alu_op        (alu_op),
        .opcode        (opcode),
        .a             (a),
        .b             (b),
        .imm           (imm),
        .pc            (pc),
        .alu_ctl       (alu_ctl),
        .result        (result),
        .zero          (zero),
        .neg           (neg),
        .carry         (carry),
        .ovf           (ovf),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the EX/MEM register should hold after one capture.
    function automatic outs_t model(input logic [1:0] op, input logic [10:0] opc,
                                    input logic [63:0] ma, input logic [63:0] mb,
                                    input logic [63:0] mimm, input logic [63:0] mpc);
        outs_t o;
        logic signed [64:0] exact;
        o = '0;
        if (op == 2'b00)      o.ctl = 4'b0010;
        else if (op == 2'b01) o.ctl = 4'b0111;
        else if (opc == OPC_SUB) o.ctl = 4'b0110;
        else if (opc == OPC_AND) o.ctl = 4'b0000;
        else if (opc == OPC_ORR) o.ctl = 4'b0001;
        else                     o.ctl = 4'b0010;

        if (o.ctl == 4'b0010) begin
            o.res = ma + mb;
            o.c   = (o.res < ma);
            exact = $signed({ma[63], ma}) + $signed({mb[63], mb});
            o.v   = (exact != $signed({o.res[63], o.res}));
        end else if (o.ctl == 4'b0110) begin
            o.res = ma - mb;
            o.c   = (ma >= mb);
            exact = $signed({ma[63], ma}) - $signed({mb[63], mb});
            o.v   = (exact != $signed({o.res[63], o.res}));
        end else if (o.ctl == 4'b0000) begin
            o.res = ma & mb;
        end else if (o.ctl == 4'b0001) begin
            o.res = ma | mb;
        end else begin
            o.res = mb;
        end
        o.z  = (o.res == 64'd0);
        o.n  = o.res[63];
        o.p4 = mpc + 64'd4;
        o.bt = mpc + mimm * 64'd4;
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] required);
        checkCount++;
        if (observed !== required) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, required);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".alu_ctl"},       64'(alu_ctl),   64'(expected.ctl));
        checkOutput({tag, ".result"},        result,         expected.res);
        checkOutput({tag, ".zero"},          64'(zero),      64'(expected.z));
        checkOutput({tag, ".neg"},           64'(neg),       64'(expected.n));
        checkOutput({tag, ".carry"},         64'(carry),     64'(expected.c));
        checkOutput({tag, ".ovf"},           64'(ovf),       64'(expected.v));
        checkOutput({tag, ".pc_plus4"},      pc_plus4,       expected.p4);
        checkOutput({tag, ".branch_target"}, branch_target,  expected.bt);
    endtask

    // Drives one cycle of inputs, advances the model, and checks after the capture edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic enable,
                                 input logic [1:0] op, input logic [10:0] opc,
                                 input logic [63:0] ia, input logic [63:0] ib,
                                 input logic [63:0] iimm, input logic [63:0] ipc);
        reset  = rst;
        en     = enable;
        alu_op = op;
        opcode = opc;
        a      = ia;
        b      = ib;
        imm    = iimm;
        pc     = ipc;
        if (rst)         expected = '0;
        else if (enable) expected = model(op, opc, ia, ib, iimm, ipc);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic [10:0] opcList [4];
        logic [63:0] edgeVals [6];
        opcList  = '{OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR};
        edgeVals = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
        reset = 1'b1; en = 1'b1; alu_op = '0; opcode = '0;
        a = '0; b = '0; imm = '0; pc = '0;
        expected = '0;
        #1;

        applyStimulus("reset", 1'b1, 1'b1, 2'b10, OPC_SUB, 64'h55, 64'h77, 64'h9, 64'h200);
        checkOutput("reset.lit.result", result, 64'd0);
        applyStimulus("release", 1'b0, 1'b1, 2'b10, OPC_SUB, 64'h55, 64'h77, 64'h9, 64'h200);

        applyStimulus("ldst", 1'b0, 1'b1, 2'b00, 11'h0, 64'h100, 64'h18, 64'd3, 64'h40);
        checkOutput("ldst.lit.result", result, 64'h118);
        checkOutput("ldst.lit.alu_ctl", 64'(alu_ctl), 64'h2);
        checkOutput("ldst.lit.pc_plus4", pc_plus4, 64'h44);
        checkOutput("ldst.lit.branch_target", branch_target, 64'h4C);

        applyStimulus("radd", 1'b0, 1'b1, 2'b10, OPC_ADD, 64'hF0, 64'h3C, 64'd0, 64'h0);
        checkOutput("radd.lit.result", result, 64'h12C);
        applyStimulus("rsub", 1'b0, 1'b1, 2'b10, OPC_SUB, 64'hF0, 64'h3C, 64'd0, 64'h4);
        checkOutput("rsub.lit.result", result, 64'hB4);
        checkOutput("rsub.lit.carry", 64'(carry), 64'd1);
        applyStimulus("rand", 1'b0, 1'b1, 2'b10, OPC_AND, 64'hF0, 64'h3C, 64'd0, 64'h8);
        checkOutput("rand.lit.result", result, 64'h30);
        applyStimulus("rorr", 1'b0, 1'b1, 2'b11, OPC_ORR, 64'hF0, 64'h3C, 64'd0, 64'hC);
        checkOutput("rorr.lit.result", result, 64'hFC);

        applyStimulus("wrap", 1'b0, 1'b1, 2'b10, OPC_SUB, 64'd0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap.lit.result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wrap.lit.pc_plus4", pc_plus4, 64'd0);
        applyStimulus("ovf", 1'b0, 1'b1, 2'b10, OPC_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h0);
        checkOutput("ovf.lit.ovf", 64'(ovf), 64'd1);

        applyStimulus("cbz0", 1'b0, 1'b1, 2'b01, 11'h0, 64'h1234, 64'd0,
                      64'hFFFF_FFFF_FFFF_FFFE, 64'h100);
        checkOutput("cbz0.lit.zero", 64'(zero), 64'd1);
        checkOutput("cbz0.lit.branch_target", branch_target, 64'hF8);
        applyStimulus("cbz5", 1'b0, 1'b1, 2'b01, 11'h0, 64'h1234, 64'd5,
                      64'hFFFF_FFFF_FFFF_FFFE, 64'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b0, 2'b10, OPC_SUB,
                          64'hDEAD, 64'hBEEF, 64'h77, 64'h3000);
        end
        checkOutput("hold.lit.result", result, 64'd5);

        applyStimulus("midreset", 1'b1, 1'b0, 2'b10, OPC_ADD, 64'h1, 64'h2, 64'h3, 64'h4);
        applyStimulus("afterreset", 1'b0, 1'b1, 2'b10, OPC_ADD, 64'h1, 64'h2, 64'h3, 64'h4);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] ra, rb, rimm, rpc;
            logic [10:0] ropc;
            logic        rrst, ren;
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rimm = {$urandom, $urandom};
            rpc  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = edgeVals[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rb = edgeVals[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            ropc = ($urandom_range(0, 4) == 4) ? 11'($urandom) : opcList[$urandom_range(0, 3)];
            rrst = ($urandom_range(0, 19) == 0);
            ren  = ($urandom_range(0, 3) != 0);
            applyStimulus($sformatf("rnd%0d", i), rrst, ren, 2'($urandom), ropc,
                          ra, rb, rimm, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Execute stage of the single-cycle LEGv8 datapath. It decodes the 4-bit ALU operation from the 2-bit ALUOp and the 11-bit opcode, and performs the 64-bit ALU operation with zero and condition flags. It also computes PC+4 and the PC-relative branch target. All results are captured in an output register (EX/MEM boundary) on the single clock.

## Interface
Parameters:
- `WIDTH`, 64: datapath width of operands, PC and results.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears every output register.
- `en`  in  1  capture enable; when low, output registers hold.
- `alu_op`  in  2  from Control; `alu_op[1]`=ALUOp1, `alu_op[0]`=ALUOp0.
- `opcode`  in  11  instruction[31:21].
- `a`  in  WIDTH  register-file read data 1.
- `b`  in  WIDTH  second operand, already selected between read data 2 and the sign-extended immediate.
- `imm`  in  WIDTH  sign-extended immediate used for the branch offset.
- `pc`  in  WIDTH  current PC.
- `alu_ctl`  out  4  registered decoded ALU operation.
- `result`  out  WIDTH  registered ALU result (data-memory address or write-back value).
- `zero`  out  1  registered; 1 iff ALU result == 0.
- `neg`, `carry`, `ovf`  out  1 each  registered N/C/V flags.
- `pc_plus4`  out  WIDTH  registered pc + 4.
- `branch_target`  out  WIDTH  registered pc + (imm << 2).

## Operation
ALU-control decode (combinational):
- `alu_op`=00 (load/store): ADD, 0010.
- `alu_op`=01 (CBZ): PASS-B, 0111.
- `alu_op`=1x (R-type), decoded from `opcode`:
  - 10001011000 ADD → 0010.
  - 11001011000 SUB → 0110.
  - 10001010000 AND → 0000.
  - 10101010000 ORR → 0001.
  - Any other opcode → ADD, 0010.

ALU operations:
- 0000 a&b.
- 0001 a|b.
- 0010 a+b.
- 0110 a−b, computed as a+~b+1.
- 0111 b.
- 1100 ~(a|b).
- Any other code → result 0.

Width and flag rules:
- Arithmetic is modulo 2^WIDTH.
- carry: carry-out of bit WIDTH−1 for ADD/SUB. For SUB, carry=1 means no borrow.
- ovf: two's-complement overflow for ADD/SUB.
- carry and ovf are 0 for logic and pass operations.
- neg = result[WIDTH−1]; zero = (result==0) for every operation.

Adders:
- pc_plus4 = pc+4, wrapping modulo 2^WIDTH.
- branch_target = pc + {imm[WIDTH−3:0],2'b00}; imm bits above WIDTH−3 are discarded by the shift.
- Both adders are instances of one generic adder.

## Timing
- All outputs are registered with a latency of 1 cycle: inputs present before rising edge N appear after edge N.
- On a reset edge, every output is 0 (alu_ctl=0000, result=0, zero=0, flags=0, pc_plus4=0, branch_target=0). Reset overrides `en`.
- When `en`=0 and `reset`=0, all outputs hold their previous values.
- Reset asserted mid-stream: the next edge clears the outputs; the edge after reset deasserts captures the current inputs normally.
- Decode and ALU paths are fully combinational between input and output registers, with no multi-cycle paths.

## Structure
- Shared package `legv8_pkg` holds:
  - ALU-control code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR.
  - ALUOp encodings.
  - R-type opcode constants: OP_ADD, OP_SUB, OP_AND, OP_ORR.
- Sub-modules:
  - `alu_ctl_decode`: combinational decode.
  - `alu_core`: combinational ALU with flags.
  - `generic_adder`, parameterized by WIDTH: instantiated twice.
- The top level holds only the output register bank.

## Test plan
- Reset: assert reset with nonzero inputs and en=1 → after the edge all outputs are 0. Deassert → the next edge captures the inputs.
- Load/store: alu_op=00, a=0x100, b=0x18, pc=0x40, imm=3 → result=0x118, alu_ctl=0010, pc_plus4=0x44, branch_target=0x4C.
- R-type set: alu_op=10 with a=0xF0, b=0x3C, applied one per cycle:
  - ADD → 0x12C.
  - SUB → 0xB4, carry=1.
  - AND → 0x30.
  - ORR → 0xFC.
- Wrap-around: SUB with a=0, b=1 → result=0xFFFF_FFFF_FFFF_FFFF, neg=1, carry=0, zero=0.
- Overflow: ADD with a=0x7FFF_FFFF_FFFF_FFFF, b=1 → ovf=1, neg=1.
- CBZ and branch: alu_op=01, b=0 → zero=1. With pc=0x100 and imm=−2 → branch_target=0xF8. Then b=5 → zero=0, result=5. With en=0 → outputs hold across 3 cycles.
